// File: rtl/dmem_responder.sv
// Target end of the CPU data port: word-wide data RAM plus a small MMIO block
// (LED, free-running timer, timer compare, status), one transaction in flight.
module dmem_responder #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ReqValid_1,
  output logic        o_ReqReady_1,
  input  logic        i_ReqWe_1,
  input  logic [31:0] i_ReqAddr_32,
  input  logic [31:0] i_ReqWData_32,
  input  logic [3:0]  i_ReqWStrb_4,
  output logic        o_RspValid_1,
  input  logic        i_RspReady_1,
  output logic [31:0] o_RspRData_32,
  output logic        o_RspErr_1,
  output logic [15:0] o_Led_16,
  output logic        o_TimerIrq_1
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} stateE;

  stateE       state, stateNext;
  logic [31:0] mem [DEPTH];
  logic [31:0] ramRdData;
  logic [15:0] ledReg;
  logic [31:0] mtime, mtimeCmp;
  logic        timerIrq;
  logic [31:0] rspData;
  logic        rspErr;

  logic          accept, isRam, mmioHit, ramLoad, ramStore;
  logic [AW-1:0] ramIdx;
  logic [1:0]    regSel;
  logic          ledWe, cmpWe, statusClr;
  logic [31:0]   rdNext;
  logic          errNext;
  logic          unusedAddrLsbs;

  assign unusedAddrLsbs = ^i_ReqAddr_32[1:0];

  function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = oldWord;
    for (int b = 0; b < 4; b++)
      if (strb[b]) merged[8*b +: 8] = newWord[8*b +: 8];
    return merged;
  endfunction

  assign accept   = i_ReqValid_1 && (state == IDLE) && !rst;
  assign isRam    = (i_ReqAddr_32 >> (AW + 2)) == 32'd0;
  assign mmioHit  = !isRam && (i_ReqAddr_32[31:4] == MMIO_BASE[31:4]);
  assign ramIdx   = i_ReqAddr_32[AW+1:2];
  assign regSel   = i_ReqAddr_32[3:2];
  assign ramLoad  = accept && isRam && !i_ReqWe_1;
  assign ramStore = accept && isRam && i_ReqWe_1;

  // Decode of everything that answers in the accept cycle (all but RAM loads).
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    rdNext    = 32'h0;
    errNext   = 1'b0;
    ledWe     = 1'b0;
    cmpWe     = 1'b0;
    statusClr = 1'b0;
    if (isRam) begin
      rdNext = 32'h0;
    end else if (mmioHit) begin
      if (i_ReqWe_1) begin
        ledWe     = accept && (regSel == 2'd0);
        cmpWe     = accept && (regSel == 2'd2);
        statusClr = accept && (regSel == 2'd3) && i_ReqWStrb_4[0] && i_ReqWData_32[0];
      end else begin
        case (regSel)
          2'd0:    rdNext = {16'h0, ledReg};
          2'd1:    rdNext = mtime;
          2'd2:    rdNext = mtimeCmp;
          default: rdNext = {31'h0, timerIrq};
        endcase
      end
    end else begin
      errNext = 1'b1;
      rdNext  = i_ReqWe_1 ? 32'h0 : ERR_DATA;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = ramLoad ? RD_WAIT : RSP;
      RD_WAIT: stateNext = RSP;
      RSP:     if (i_RspReady_1) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ledReg   <= 16'h0;
      mtime    <= 32'h0;
      mtimeCmp <= 32'hFFFF_FFFF;
      timerIrq <= 1'b0;
      rspData  <= 32'h0;
      rspErr   <= 1'b0;
    end else begin
      mtime <= mtime + 32'd1;
      if (ledWe) begin
        if (i_ReqWStrb_4[0]) ledReg[7:0]  <= i_ReqWData_32[7:0];
        if (i_ReqWStrb_4[1]) ledReg[15:8] <= i_ReqWData_32[15:8];
      end
      if (cmpWe) mtimeCmp <= mergeLanes(mtimeCmp, i_ReqWData_32, i_ReqWStrb_4);
      // A match in the same cycle as a software clear keeps the flag set.
      if (mtime == mtimeCmp) timerIrq <= 1'b1;
      else if (statusClr)    timerIrq <= 1'b0;
      if (accept && !ramLoad) begin
        rspData <= rdNext;
        rspErr  <= errNext;
      end else if (state == RD_WAIT) begin
        rspData <= ramRdData;
        rspErr  <= 1'b0;
      end
    end
  end

  // NOTE: the RAM array and its read register carry no reset so the array maps
  // onto block RAM; software must not rely on power-up contents.
  always_ff @(posedge clk) begin
    if (ramStore)
      for (int b = 0; b < 4; b++)
        if (i_ReqWStrb_4[b]) mem[ramIdx][8*b +: 8] <= i_ReqWData_32[8*b +: 8];
    if (ramLoad) ramRdData <= mem[ramIdx];
  end

  assign o_ReqReady_1  = (state == IDLE);
  assign o_RspValid_1  = (state == RSP);
  assign o_RspRData_32 = rspData;
  assign o_RspErr_1    = rspErr;
  assign o_Led_16      = ledReg;
  assign o_TimerIrq_1  = timerIrq;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, MMIO, timer irq, backpressure and
// reset behaviour, checked with immediate assertions against hand values.
module tb_dmem_responder;

  localparam logic [31:0] MMIO = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqWe, rspReady;
  logic [31:0] reqAddr, reqWData;
  logic [3:0]  reqWStrb;
  logic        reqReady, rspValid, rspErr, timerIrq;
  logic [31:0] rspRData;
  logic [15:0] led;

  logic [31:0] tbTime;
  int          checks = 0;
  int          errors = 0;

  dmem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .i_ReqValid_1 (reqValid),
    .o_ReqReady_1 (reqReady),
    .i_ReqWe_1    (reqWe),
    .i_ReqAddr_32 (reqAddr),
    .i_ReqWData_32(reqWData),
    .i_ReqWStrb_4 (reqWStrb),
    .o_RspValid_1 (rspValid),
    .i_RspReady_1 (rspReady),
    .o_RspRData_32(rspRData),
    .o_RspErr_1   (rspErr),
    .o_Led_16     (led),
    .o_TimerIrq_1 (timerIrq)
  );

  always #5 clk = ~clk;

  // Reference timer: counts rising edges since reset released.
  always @(posedge clk) begin
    if (rst) tbTime <= 32'h0;
    else     tbTime <= tbTime + 32'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called and returns at a negedge; rspReady is expected to be 1.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                      output int lat, output logic [31:0] accTime);
    int n;
    reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWData = wdata; reqWStrb = strb;
    n = 0;
    while (!reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_accept", reqReady, 1'b1);
    accTime = tbTime;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    lat = 1;
    while (!rspValid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rdata = rspRData;
    err   = rspErr;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] rd, acc, cmp;
  logic        er;
  int          lat;

  task automatic waitTime(input logic [31:0] target);
    int n;
    n = 0;
    while (tbTime != target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_time_reached", tbTime, target);
  endtask

  initial begin
    rst = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWData = '0;
    reqWStrb = '0; rspReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", reqReady, 1'b1);
    check("rst_rsp_valid", rspValid, 1'b0);
    check("rst_led", led, 16'h0);
    check("rst_irq", timerIrq, 1'b0);
    check("rst_rdata", rspRData, 32'h0);
    check("rst_err", rspErr, 1'b0);
    rst = 1'b0;

    // MTIME read accepted on the 10th edge after reset release
    repeat (9) @(negedge clk);
    xact(1'b0, MMIO + 32'h4, 32'h0, 4'h0, rd, er, lat, acc);
    check("mtime_first_read", rd, 32'd9);
    check("mtime_lat", lat, 1);

    // RAM byte-lane stores and load-back
    xact(1'b1, 32'h40, 32'h1234_5678, 4'b1111, rd, er, lat, acc);
    check("st_lat", lat, 1);
    check("st_rdata", rd, 32'h0);
    check("st_err", er, 1'b0);
    xact(1'b1, 32'h40, 32'h0000_AB00, 4'b0010, rd, er, lat, acc);
    xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat, acc);
    check("ld_rdata", rd, 32'h1234_AB78);
    check("ld_lat", lat, 2);
    check("ld_err", er, 1'b0);

    // Backpressure: response held for 5 cycles with a second request waiting
    rspReady = 1'b0;
    reqValid = 1'b1; reqWe = 1'b0; reqAddr = 32'h40; reqWStrb = 4'h0;
    check("bp_ready_idle", reqReady, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reqWe = 1'b1; reqAddr = 32'h44; reqWData = 32'hCAFE_F00D; reqWStrb = 4'hF;
    check("bp_rdwait_ready", reqReady, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", rspValid, 1'b1);
      check("bp_data_held", rspRData, 32'h1234_AB78);
      check("bp_ready_low", reqReady, 1'b0);
      if (i < 4) @(negedge clk);
    end
    rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_post_hs_valid", rspValid, 1'b0);
    check("bp_post_hs_ready", reqReady, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    check("bp_second_rsp", rspValid, 1'b1);
    check("bp_second_err", rspErr, 1'b0);
    @(posedge clk);
    @(negedge clk);
    xact(1'b0, 32'h44, 32'h0, 4'h0, rd, er, lat, acc);
    check("bp_second_store_data", rd, 32'hCAFE_F00D);

    // LED lanes
    xact(1'b1, MMIO, 32'hFFFF_A5A5, 4'b0001, rd, er, lat, acc);
    check("led_lane0", led, 16'h00A5);
    xact(1'b1, MMIO, 32'h0000_3C00, 4'b0010, rd, er, lat, acc);
    check("led_lane1", led, 16'h3CA5);
    xact(1'b0, MMIO, 32'h0, 4'h0, rd, er, lat, acc);
    check("led_read", rd, 32'h0000_3CA5);
    check("led_read_lat", lat, 1);

    // Unmapped and no-op accesses
    xact(1'b0, 32'h2000_0000, 32'h0, 4'h0, rd, er, lat, acc);
    check("unmap_ld_data", rd, 32'hDEAD_BEEF);
    check("unmap_ld_err", er, 1'b1);
    check("unmap_ld_lat", lat, 1);
    xact(1'b1, MMIO + 32'h10, 32'h0000_0000, 4'hF, rd, er, lat, acc);
    check("unmap_st_err", er, 1'b1);
    check("unmap_st_rdata", rd, 32'h0);
    check("unmap_st_led", led, 16'h3CA5);
    xact(1'b0, MMIO + 32'h8, 32'h0, 4'h0, rd, er, lat, acc);
    check("cmp_reset_value", rd, 32'hFFFF_FFFF);
    xact(1'b1, MMIO + 32'h4, 32'h0, 4'hF, rd, er, lat, acc);
    check("mtime_write_err", er, 1'b0);
    xact(1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0, rd, er, lat, acc);
    check("strb0_err", er, 1'b0);
    xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat, acc);
    check("strb0_no_change", rd, 32'h1234_AB78);

    // Timer compare, sticky irq, clear
    cmp = tbTime + 32'd20;
    xact(1'b1, MMIO + 32'h8, cmp, 4'hF, rd, er, lat, acc);
    xact(1'b0, MMIO + 32'h8, 32'h0, 4'h0, rd, er, lat, acc);
    check("cmp_readback", rd, cmp);
    waitTime(cmp - 32'd1);
    check("irq_before_match", timerIrq, 1'b0);
    waitTime(cmp + 32'd1);
    check("irq_after_match", timerIrq, 1'b1);
    waitTime(cmp + 32'd6);
    check("irq_sticky", timerIrq, 1'b1);
    xact(1'b0, MMIO + 32'hC, 32'h0, 4'h0, rd, er, lat, acc);
    check("status_read_set", rd, 32'h1);
    xact(1'b1, MMIO + 32'hC, 32'h1, 4'b0001, rd, er, lat, acc);
    check("irq_cleared", timerIrq, 1'b0);
    xact(1'b0, MMIO + 32'hC, 32'h0, 4'h0, rd, er, lat, acc);
    check("status_read_clear", rd, 32'h0);

    // Clear accepted in the match cycle: set wins
    cmp = tbTime + 32'd12;
    xact(1'b1, MMIO + 32'h8, cmp, 4'hF, rd, er, lat, acc);
    waitTime(cmp);
    xact(1'b1, MMIO + 32'hC, 32'h1, 4'b0001, rd, er, lat, acc);
    check("clr_in_match_cycle", acc, cmp);
    check("irq_set_wins", timerIrq, 1'b1);

    // Reset while the load sits in RD_WAIT
    reqValid = 1'b1; reqWe = 1'b0; reqAddr = 32'h40; reqWStrb = 4'h0;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    check("rdwait_valid", rspValid, 1'b0);
    check("rdwait_ready", reqReady, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", rspValid, 1'b0);
    check("midrst_ready", reqReady, 1'b1);
    check("midrst_led", led, 16'h0);
    check("midrst_irq", timerIrq, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_dropped", rspValid, 1'b0);
    xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat, acc);
    check("ram_survives_rst", rd, 32'h1234_AB78);
    check("ram_ld_lat_after_rst", lat, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
